fft_16_4_ctrl: RTL and testbench
================================

Name: fft_16_4_ctrl

Overview:
Frame sequencer and flow controller in front of the fft_16_4 core. Collects 4 upstream beats of 4 complex samples into one 16-point frame, issues it to the core as 4 back-to-back beats, and tracks frames in flight. Captures each 16-bin core result into an output FIFO that supports backpressure. Credit accounting means a core result is never dropped, since the core itself has no stall input.

Parameters:
INPUT_WIDTH, 16, bits per real/imag input component
OUTPUT_WIDTH, 20, bits per real/imag output component
OUT_DEPTH, 2, output FIFO depth in frames (>=1)
TIMEOUT, 64, max cycles from frame issue to core result (used only with FFT_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_sync_n  in  1  synchronous active-low reset
s_valid  in  1  upstream beat valid
s_ready  out  1  upstream beat ready
s_data  in  [INPUT_WIDTH-1:0] [4][2]  4 complex samples, [k][0]=re, [k][1]=im
core_i_valid  out  1  beat valid to core
core_i_data  out  [INPUT_WIDTH-1:0] [4][2]  beat to core
core_o_valid  in  1  core frame result valid (1-cycle pulse)
core_o_data  in  [OUTPUT_WIDTH-1:0] [16][2]  core result bins
m_valid  out  1  output frame valid
m_ready  in  1  downstream ready
m_data  out  [OUTPUT_WIDTH-1:0] [16][2]  FIFO head frame
inflight  out  $clog2(OUT_DEPTH+1)  frames issued but not yet returned
err_unexp  out  1  sticky: core_o_valid seen with inflight==0

Behaviour:
- Reset: all outputs 0 (s_ready=0, core_i_valid=0, core_i_data=0, m_valid=0, m_data=0, inflight=0, err_unexp=0); FSM->COLLECT; beat_cnt=0; FIFO empty. Reset mid-frame discards any partial or staged frame.
- Beat handshake: a beat transfers when s_valid&&s_ready. The 4 beats of a frame are stored in order in a staging buffer as stage[beat_cnt].
- Credit: credit = OUT_DEPTH - fifo_count - inflight, always >= 0.
- FSM COLLECT:
  - s_ready=1.
  - Accept a beat: beat_cnt++.
  - Accepting beat 3: go to ISSUE if credit>0, else WAIT_CREDIT. In both cases beat_cnt wraps to 0.
- FSM WAIT_CREDIT:
  - s_ready=0.
  - Go to ISSUE in the cycle after credit>0 is observed. A FIFO pop, or an inflight decrement caused by a result capture, frees credit.
- FSM ISSUE:
  - 4 consecutive cycles; s_ready=0; core_i_valid=1; core_i_data=stage[issue_cnt], issue_cnt 0..3.
  - inflight increments in the first ISSUE cycle.
  - After cycle 3, go to COLLECT.
  - core_i_data is registered; core_i_valid=0 outside ISSUE.
- Latency: first core beat appears 1 cycle after the 4th upstream beat is accepted, given credit.
- Result capture:
  - core_o_valid && inflight>0: push core_o_data to the FIFO tail and decrement inflight.
  - core_o_valid && inflight==0: no push, set err_unexp. err_unexp clears only on reset.
- FIFO:
  - m_valid = !empty; m_data = head entry, registered storage.
  - Pop on m_valid&&m_ready.
  - Push and pop in the same cycle are both honoured; fifo_count is unchanged.
  - Push into a full FIFO cannot occur by construction.
  - Pointers wrap modulo OUT_DEPTH.
- Simultaneous events:
  - inflight increment (ISSUE start) and decrement (capture) in the same cycle: net 0.
  - Pop and capture in the same cycle: credit = OUT_DEPTH - fifo_count - inflight, where fifo_count is unchanged and inflight drops by 1, so credit rises by 1.
- No combinational path from m_ready to s_ready or from core_o_valid to core_i_valid.

Optional Feature:
FFT_CTRL_TIMEOUT_EN
- Defined:
  - Adds output port err_timeout (1 bit, sticky, reset 0).
  - A counter runs while inflight>0 and resets on each capture.
  - When the counter reaches TIMEOUT: set err_timeout, force inflight to 0, and release the credit.
- Undefined: no counter and no port; behaviour is otherwise identical.

Test Plan:
- Single frame, OUT_DEPTH=2: 4 beats with samples 0..15 (re=n, im=0), m_ready=1.
  - Response: core_i_valid high for 4 cycles starting the cycle after beat 3, beats in order; inflight=1.
  - Model core returns after 10 cycles; m_valid rises next cycle with m_data == core_o_data; inflight=0.
- Backpressure, m_ready=0, 3 frames sent:
  - Frames 1 and 2 are issued; frame 3 is staged and the FSM sits in WAIT_CREDIT with s_ready=0.
  - Raise m_ready for 1 cycle: exactly one pop, then frame 3 is issued.
- Gapped input: s_valid toggles 1,0,1,0,... -> beats are assembled in order and frame content is unchanged.
- Spurious result: pulse core_o_valid with inflight=0 -> err_unexp=1 and stays 1; FIFO stays empty.
- Reset mid-issue: assert rst_sync_n=0 on the 2nd ISSUE cycle -> next cycle all outputs 0 and FSM in COLLECT; a following frame behaves as in the single-frame test.
- FFT_CTRL_TIMEOUT_EN with TIMEOUT=64: issue a frame with no core result -> err_timeout=1 at cycle 64, inflight=0, and the next frame is issued without delay.

Source files
------------

// File: rtl/fft_16_4_ctrl_if.sv
// Bus bundle for fft_16_4_ctrl: upstream beat stream, core beat/result
// signals and the downstream frame stream. The controller takes the slave
// modport; the environment driving it takes the master modport.
interface fft_16_4_ctrl_if #(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 20
);
  logic                                    s_valid;
  logic                                    s_ready;
  logic [3:0][1:0][INPUT_WIDTH-1:0]        s_data;
  logic                                    core_i_valid;
  logic [3:0][1:0][INPUT_WIDTH-1:0]        core_i_data;
  logic                                    core_o_valid;
  logic [15:0][1:0][OUTPUT_WIDTH-1:0]      core_o_data;
  logic                                    m_valid;
  logic                                    m_ready;
  logic [15:0][1:0][OUTPUT_WIDTH-1:0]      m_data;

  modport slave (
    input  s_valid, s_data, core_o_valid, core_o_data, m_ready,
    output s_ready, core_i_valid, core_i_data, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, core_o_valid, core_o_data, m_ready,
    input  s_ready, core_i_valid, core_i_data, m_valid, m_data
  );
endinterface

// File: rtl/fft_16_4_ctrl.sv
// Frame sequencer / flow controller in front of the fft_16_4 core.
// Collects 4 upstream beats into a staged 16-point frame, issues it to the
// core as 4 back-to-back beats, and captures each result into an output
// FIFO. Issue is gated on credit (FIFO space not already promised to frames
// in flight), so a result from the stall-free core always has a slot.
// Optional: define FFT_CTRL_TIMEOUT_EN to add the err_timeout port and a
// watchdog that abandons frames whose result never returns.
module fft_16_4_ctrl #(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 20,
  parameter int OUT_DEPTH    = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                           clk,
  input  logic                           rst_sync_n,
  fft_16_4_ctrl_if.slave                 bus,
  output logic [$clog2(OUT_DEPTH+1)-1:0] inflight,
  output logic                           err_unexp
`ifdef FFT_CTRL_TIMEOUT_EN
  ,
  output logic                           err_timeout
`endif
);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_V = (CW + 1)'(OUT_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUT_DEPTH - 1);

  typedef logic [3:0][1:0][INPUT_WIDTH-1:0]   beat_t;
  typedef logic [15:0][1:0][OUTPUT_WIDTH-1:0] frame_t;
  typedef enum logic [1:0] {COLLECT, WAIT_CREDIT, ISSUE} state_t;

  state_t          state, next_state;
  logic [1:0]      beat_cnt, issue_cnt, next_issue_cnt;
  beat_t [3:0]     stage;
  frame_t          mem [OUT_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count, inflight_d;
  logic [CW:0]     used;
  logic            s_ready_d, core_i_valid_d;
  beat_t           core_i_data_d;
  logic            beat_acc, push, pop, spurious, has_credit, issue_start;
  logic            tmo_hit;

  assign beat_acc    = bus.s_valid && bus.s_ready;
  assign push        = bus.core_o_valid && (inflight != '0);
  assign spurious    = bus.core_o_valid && (inflight == '0);
  assign pop         = bus.m_valid && bus.m_ready;
  assign used        = {1'b0, fifo_count} + {1'b0, inflight};
  assign has_credit  = used < DEPTH_V;
  assign issue_start = (state != ISSUE) && (next_state == ISSUE);

  // State register; handshake outputs are registered from the next state
  // so neither m_ready nor core_o_valid reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      state            <= COLLECT;
      issue_cnt        <= '0;
      bus.s_ready      <= 1'b0;
      bus.core_i_valid <= 1'b0;
      bus.core_i_data  <= '0;
    end else begin
      state            <= next_state;
      issue_cnt        <= next_issue_cnt;
      bus.s_ready      <= s_ready_d;
      bus.core_i_valid <= core_i_valid_d;
      bus.core_i_data  <= core_i_data_d;
    end
  end

  // Next-state: collect 4 beats, wait for credit if needed, issue 4 beats.
  always_comb begin
    next_state = state;
    unique case (state)
      COLLECT:     if (beat_acc && beat_cnt == 2'd3)
                     next_state = has_credit ? ISSUE : WAIT_CREDIT;
      WAIT_CREDIT: if (has_credit) next_state = ISSUE;
      ISSUE:       if (issue_cnt == 2'd3) next_state = COLLECT;
      default:     next_state = COLLECT;
    endcase
  end

  // Output decode for the coming cycle, registered above.
  always_comb begin
    next_issue_cnt = '0;
    core_i_valid_d = 1'b0;
    core_i_data_d  = '0;
    s_ready_d      = (next_state == COLLECT);
    if (next_state == ISSUE) begin
      next_issue_cnt = (state == ISSUE) ? issue_cnt + 2'd1 : 2'd0;
      core_i_valid_d = 1'b1;
      core_i_data_d  = stage[next_issue_cnt];
    end
  end

  // Staging buffer: beats stored in arrival order.
  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      beat_cnt <= '0;
      stage    <= '0;
    end else if (beat_acc) begin
      stage[beat_cnt] <= bus.s_data;
      beat_cnt        <= beat_cnt + 2'd1;
    end
  end

  // Frames-in-flight bookkeeping; issue and capture in one cycle cancel.
  always_comb begin
    inflight_d = inflight;
    if (push)        inflight_d = inflight_d - CW'(1);
    if (tmo_hit)     inflight_d = '0;
    if (issue_start) inflight_d = inflight_d + CW'(1);
  end

  // Inflight counter and sticky unexpected-result flag.
  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      inflight  <= '0;
      err_unexp <= 1'b0;
    end else begin
      inflight <= inflight_d;
      if (spurious) err_unexp <= 1'b1;
    end
  end

  // Output FIFO: push on result capture, pop on downstream handshake.
  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.core_o_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.m_valid = (fifo_count != '0);
  assign bus.m_data  = mem[rd_ptr];

`ifdef FFT_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (inflight != '0) && !push && (tmo_cnt == TW'(TIMEOUT - 1));

  // Watchdog: counts while frames are outstanding, restarts on each capture.
  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (inflight == '0 || push || tmo_hit) tmo_cnt <= '0;
      else                                   tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif
endmodule

// File: tb/tb_fft_16_4_ctrl.sv
// Self-checking bench for fft_16_4_ctrl: a behavioural core model returns
// random results a fixed time after each frame; a queue-based scoreboard
// predicts issued beats, FIFO contents, inflight and error flags.
module tb_fft_16_4_ctrl;
  localparam int IW    = 16;
  localparam int OW    = 20;
  localparam int DEPTH = 2;
  localparam int TMO   = 64;
  localparam int LAT   = 10;
  localparam int FW    = 16 * 2 * OW;
  localparam int BW    = 4 * 2 * IW;

  logic       clk = 1'b0;
  logic       rst_sync_n;
  logic [1:0] inflight;
  logic       err_unexp;
`ifdef FFT_CTRL_TIMEOUT_EN
  logic       err_timeout;
`endif

  fft_16_4_ctrl_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

  fft_16_4_ctrl #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .OUT_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_sync_n(rst_sync_n), .bus(bus.slave),
    .inflight(inflight), .err_unexp(err_unexp)
`ifdef FFT_CTRL_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [BW-1:0] exp_beats[$];
  logic [FW-1:0] exp_out[$];
  int            due_q[$];
  int            cyc = 0;
  int            m_infl = 0;
  bit            m_err = 0;
  int            core_beat = 0;
  bit            core_auto = 1;
  bit            spur_req = 0;
  bit            rand_ready = 0;
`ifdef FFT_CTRL_TIMEOUT_EN
  bit            m_tmo = 0;
  int            last_evt = 0;
`endif

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  // One clock: update model from the pre-edge handshakes, check, then drive core.
  task automatic tick();
    bit hs, pp, cap, rst_pre;
    int infl_before;
    logic [BW-1:0] beat;
    logic [FW-1:0] head, res;
    hs = bus.s_valid && bus.s_ready; beat = bus.s_data;
    pp = bus.m_valid && bus.m_ready; head = bus.m_data;
    cap = bus.core_o_valid; res = bus.core_o_data;
    rst_pre = !rst_sync_n;
    @(posedge clk); #1; cyc++;
    if (rst_pre) begin
      exp_beats.delete(); exp_out.delete(); due_q.delete();
      m_infl = 0; m_err = 0; core_beat = 0;
`ifdef FFT_CTRL_TIMEOUT_EN
      m_tmo = 0;
`endif
    end else begin
      infl_before = m_infl;
      if (pp) begin
        if (exp_out.size() == 0) check("pop_unexpected", pp, 0);
        else check("m_data", head, exp_out.pop_front());
      end
      if (cap) begin
        if (m_infl > 0) begin exp_out.push_back(res); m_infl--; end
        else m_err = 1;
      end
      if (hs) exp_beats.push_back(beat);
      if (bus.core_i_valid) begin
        if (core_beat == 0) m_infl++;
        if (exp_beats.size() == 0) check("core_beat_extra", bus.core_i_valid, 0);
        else check("core_beat", bus.core_i_data, exp_beats.pop_front());
        core_beat = (core_beat + 1) % 4;
        if (core_beat == 0 && core_auto) due_q.push_back(cyc + LAT);
      end
`ifdef FFT_CTRL_TIMEOUT_EN
      if ((cap && infl_before > 0) || (infl_before == 0 && m_infl > 0)) last_evt = cyc;
      if (m_infl > 0 && cyc - last_evt >= TMO) begin m_infl = 0; m_tmo = 1; end
      check("err_timeout", err_timeout, m_tmo);
`endif
      check("inflight", inflight, m_infl);
      check("err_unexp", err_unexp, m_err);
      check("m_valid", bus.m_valid, exp_out.size() != 0);
    end
    bus.core_o_valid = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      bus.core_o_valid = 1'b1; bus.core_o_data = rand_frame();
    end else if (spur_req) begin
      spur_req = 0;
      bus.core_o_valid = 1'b1; bus.core_o_data = rand_frame();
    end
    if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [BW-1:0] b [4], input bit gapped);
    for (int k = 0; k < 4; k++) begin
      int t;
      bit acc;
      bus.s_valid = 1'b1; bus.s_data = b[k]; t = 0; acc = 0;
      while (!acc && t < 200) begin acc = bus.s_ready; tick(); t++; end
      if (!acc) check("s_ready_wait", acc, 1);
      bus.s_valid = 1'b0;
      if (gapped && k < 3) tick();
      else if (gapped === 1'b0 && k < 3 && $urandom_range(0, 3) == 0 && rand_ready) tick();
    end
  endtask

  task automatic ramp_frame(output logic [BW-1:0] b [4]);
    for (int k = 0; k < 4; k++) begin
      b[k] = '0;
      for (int j = 0; j < 4; j++) b[k][(j*2)*IW +: IW] = IW'(4 * k + j);
    end
  endtask

  task automatic rand_beats(output logic [BW-1:0] b [4]);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < BW / 32; i++) b[k][i*32 +: 32] = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_out.size() != 0 || m_infl != 0 || due_q.size() != 0) && t < 200) begin
      tick(); t++;
    end
    check("drain_done", bus.m_valid, 0);
  endtask

  task automatic single_frame();
    logic [BW-1:0] fr [4];
    int t;
    ramp_frame(fr);
    send_frame(fr, 0);
    check("issue_latency", bus.core_i_valid, 1);
    check("inflight_issue", inflight, 1);
    for (int i = 0; i < 3; i++) begin tick(); check("issue_hold", bus.core_i_valid, 1); end
    tick(); check("issue_end", bus.core_i_valid, 0);
    t = 0;
    while (!bus.m_valid && t < 40) begin tick(); t++; end
    check("result_arrives", bus.m_valid, 1);
    check("inflight_after", inflight, 0);
    drain();
  endtask

  initial begin
    logic [BW-1:0] fr [4];
    int t;
    rst_sync_n = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    bus.core_o_valid = 1'b0; bus.core_o_data = '0;
    bus.m_ready = 1'b1;
    tick();
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_core_i_valid", bus.core_i_valid, 0);
    check("rst_core_i_data", bus.core_i_data, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_inflight", inflight, 0);
    check("rst_err_unexp", err_unexp, 0);
    repeat (2) tick();
    rst_sync_n = 1'b1;
    tick();

    single_frame();

    rand_beats(fr);
    send_frame(fr, 1);
    drain();

    // Backpressure: third frame must wait for credit
    bus.m_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin rand_beats(fr); send_frame(fr, 0); end
    repeat (LAT + 10) tick();
    check("bp_s_ready", bus.s_ready, 0);
    check("bp_no_issue", bus.core_i_valid, 0);
    check("bp_m_valid", bus.m_valid, 1);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    check("bp_one_pop_no_issue", bus.core_i_valid, 0);
    check("bp_one_left", bus.m_valid, 1);
    tick();
    check("bp_issue_after_pop", bus.core_i_valid, 1);
    bus.m_ready = 1'b1;
    drain();

    // Spurious core result
    spur_req = 1;
    repeat (6) tick();
    check("err_sticky", err_unexp, 1);
    check("spur_no_push", bus.m_valid, 0);

    // Reset during the 2nd issue cycle
    rand_beats(fr);
    send_frame(fr, 0);
    tick();
    check("mid_issue", bus.core_i_valid, 1);
    rst_sync_n = 1'b0;
    tick();
    check("mrst_s_ready", bus.s_ready, 0);
    check("mrst_core_i_valid", bus.core_i_valid, 0);
    check("mrst_core_i_data", bus.core_i_data, 0);
    check("mrst_m_valid", bus.m_valid, 0);
    check("mrst_m_data", bus.m_data, 0);
    check("mrst_inflight", inflight, 0);
    check("mrst_err_unexp", err_unexp, 0);
    rst_sync_n = 1'b1;
    single_frame();

    // Randomized traffic with random downstream ready
    rand_ready = 1;
    for (int f = 0; f < 8; f++) begin rand_beats(fr); send_frame(fr, 1'($urandom_range(0, 1))); end
    rand_ready = 0;
    bus.m_ready = 1'b1;
    drain();

`ifdef FFT_CTRL_TIMEOUT_EN
    core_auto = 0;
    rand_beats(fr);
    send_frame(fr, 0);
    t = 0;
    while (!err_timeout && t < 200) begin tick(); t++; end
    check("tmo_cycles", t, TMO);
    check("tmo_inflight", inflight, 0);
    core_auto = 1;
    rand_beats(fr);
    send_frame(fr, 0);
    check("tmo_next_issue", bus.core_i_valid, 1);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
